// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle between the control unit (master)
//                and the sequential ALU (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] accum;
    logic [WIDTH-1:0] alu_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             z;
    logic             c;
    logic             n;
    logic             v;
    logic             err;

    modport master (
        output start, alu_sel, accum, alu_in,
        input  busy, done, result, result_hi, z, c, n, v, err
    );

    modport slave (
        input  start, alu_sel, accum, alu_in,
        output busy, done, result, result_hi, z, c, n, v, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked ALU with registered result/flags, bit-serial
//                shifts and a WIDTH-cycle shift-add unsigned multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    // One extra bit so the counter holds both WIDTH and the largest shift amount
    localparam int              c_CW       = SHW + 1;
    localparam logic [c_CW-1:0] c_MUL_ITER = c_CW'(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_NOR  = 4'b0011;
    localparam logic [3:0] c_OP_MOVR = 4'b0100;
    localparam logic [3:0] c_OP_SHL  = 4'b1011;
    localparam logic [3:0] c_OP_SHR  = 4'b1100;
    localparam logic [3:0] c_OP_MUL  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_z, r_c, r_n, r_v, r_err;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_is_mul;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_step_lo;
    logic             w_step_c;
    logic [c_CW-1:0]  w_cnt_dec;
    logic             w_complete;
    logic             w_illegal;
    logic [WIDTH-1:0] w_fin_res;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_c;
    logic             w_fin_v;

    // Request decode and per-iteration datapath (one shift bit / one multiply step)
    always_comb begin
        w_accept   = (r_state == S_IDLE) && bus.start;
        w_is_shift = (bus.alu_sel == c_OP_SHL) || (bus.alu_sel == c_OP_SHR);
        w_is_mul   = (bus.alu_sel == c_OP_MUL);
        w_amt      = bus.alu_in[SHW-1:0];
        w_add      = {1'b0, bus.accum} + {1'b0, bus.alu_in};
        w_sub      = {1'b0, bus.accum} - {1'b0, bus.alu_in};
        // Product accumulates in r_hi while the multiplier drains out of r_lo
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_mul_hi   = w_mul_sum[WIDTH:1];
        w_mul_lo   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_cnt_dec  = r_cnt - c_CW'(1);
        w_step_lo  = {1'b0, r_lo[WIDTH-1:1]};
        w_step_c   = r_lo[0];
        if (r_op == c_OP_MUL) begin
            w_step_lo = w_mul_lo;
            w_step_c  = 1'b0;
        end else if (r_op == c_OP_SHL) begin
            w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
            w_step_c  = r_lo[WIDTH-1];
        end
    end

    // Next-state and completion values; results are only committed when w_complete
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_illegal    = 1'b0;
        w_fin_res    = r_result;
        w_fin_hi     = '0;
        w_fin_c      = 1'b0;
        w_fin_v      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_DONE;
                    case (bus.alu_sel)
                        c_OP_ADD: begin
                            w_complete = 1'b1;
                            w_fin_res  = w_add[WIDTH-1:0];
                            w_fin_c    = w_add[WIDTH];
                            w_fin_v    = (bus.accum[WIDTH-1] == bus.alu_in[WIDTH-1]) &&
                                         (w_add[WIDTH-1] != bus.accum[WIDTH-1]);
                        end
                        c_OP_SUB: begin
                            w_complete = 1'b1;
                            w_fin_res  = w_sub[WIDTH-1:0];
                            w_fin_c    = w_sub[WIDTH];
                            w_fin_v    = (bus.accum[WIDTH-1] != bus.alu_in[WIDTH-1]) &&
                                         (w_sub[WIDTH-1] != bus.accum[WIDTH-1]);
                        end
                        c_OP_NOR: begin
                            w_complete = 1'b1;
                            w_fin_res  = ~(bus.accum | bus.alu_in);
                        end
                        c_OP_MOVR: begin
                            w_complete = 1'b1;
                            w_fin_res  = bus.alu_in;
                        end
                        c_OP_SHL, c_OP_SHR: begin
                            if (w_amt == '0) begin
                                w_complete = 1'b1;
                                w_fin_res  = bus.accum;
                            end else begin
                                w_state_next = S_RUN;
                            end
                        end
                        c_OP_MUL: w_state_next = S_RUN;
                        default:  w_illegal = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                if (w_cnt_dec == '0) begin
                    w_state_next = S_DONE;
                    w_complete   = 1'b1;
                    w_fin_res    = w_step_lo;
                    if (r_op == c_OP_MUL) begin
                        w_fin_hi = w_mul_hi;
                        w_fin_c  = |w_mul_hi;
                    end else begin
                        w_fin_c  = w_step_c;
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Operand capture at accept, then one shift/multiply step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_a   <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op <= bus.alu_sel;
            r_a  <= bus.accum;
            r_hi <= '0;
            r_lo <= w_is_shift ? bus.accum : bus.alu_in;
            if (w_is_shift)    r_cnt <= {1'b0, w_amt};
            else if (w_is_mul) r_cnt <= c_MUL_ITER;
            else               r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= w_cnt_dec;
            r_lo  <= w_step_lo;
            r_hi  <= w_mul_hi;
        end
    end

    // Result/flag registers change only on the edge that completes an op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_illegal;
            if (w_complete) begin
                r_result    <= w_fin_res;
                r_result_hi <= w_fin_hi;
                // result_hi is zero for non-MUL ops, so this covers both zero rules
                r_z         <= ~|{w_fin_hi, w_fin_res};
                r_c         <= w_fin_c;
                r_n         <= w_fin_res[WIDTH-1];
                r_v         <= w_fin_v;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.z         = r_z;
    assign bus.c         = r_c;
    assign bus.n         = r_n;
    assign bus.v         = r_v;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq, WIDTH=8 and 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam logic [3:0] c_ADD = 4'b0001, c_SUB = 4'b0010, c_NOR = 4'b0011;
    localparam logic [3:0] c_SHL = 4'b1011, c_SHR = 4'b1100, c_MUL = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel16;
    logic        t_start;
    logic [3:0]  t_op;
    logic [31:0] t_a, t_b;
    logic [31:0] o_res, o_hi;
    logic        o_z, o_c, o_n, o_v, o_err, o_done, o_busy;
    int          errors = 0;
    int          checks = 0;
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  b8 ();
    alu_seq_if #(.WIDTH(16)) b16 ();

    alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    assign b8.start    = t_start & ~sel16;
    assign b8.alu_sel  = t_op;
    assign b8.accum    = t_a[7:0];
    assign b8.alu_in   = t_b[7:0];
    assign b16.start   = t_start & sel16;
    assign b16.alu_sel = t_op;
    assign b16.accum   = t_a[15:0];
    assign b16.alu_in  = t_b[15:0];

    assign o_res  = sel16 ? {16'h0, b16.result}    : {24'h0, b8.result};
    assign o_hi   = sel16 ? {16'h0, b16.result_hi} : {24'h0, b8.result_hi};
    assign o_z    = sel16 ? b16.z    : b8.z;
    assign o_c    = sel16 ? b16.c    : b8.c;
    assign o_n    = sel16 ? b16.n    : b8.n;
    assign o_v    = sel16 ? b16.v    : b8.v;
    assign o_err  = sel16 ? b16.err  : b8.err;
    assign o_done = sel16 ? b16.done : b8.done;
    assign o_busy = sel16 ? b16.busy : b8.busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns latency counted with the accept edge as 1.
    // Operands are scrambled after accept; optional ADD pulse while busy.
    task automatic issue(input bit w16, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inject, output int l);
        @(negedge clk);
        sel16 = w16; t_op = op; t_a = a; t_b = b; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0; t_a = ~a; t_b = ~b;
        l = 1;
        while (!o_done && l < 40) begin
            @(posedge clk); #1;
            l++;
            if (inject && l == 3) begin
                t_op = c_ADD; t_a = 32'h1; t_b = 32'h1; t_start = 1'b1;
            end else if (inject && l == 4) begin
                t_start = 1'b0;
            end
        end
        t_start = 1'b0;
    endtask

    // Check the done cycle, then that done/err/busy drop on the following edge
    task automatic expect_done(input string tag, input int l, input int exp_l,
                               input logic [31:0] r, input logic [31:0] h,
                               input logic [3:0] zcnv, input logic e);
        chk({tag, ".lat"},   l, exp_l);
        chk({tag, ".done"},  {31'h0, o_done}, 32'h1);
        chk({tag, ".busy"},  {31'h0, o_busy}, 32'h1);
        chk({tag, ".res"},   o_res, r);
        chk({tag, ".hi"},    o_hi, h);
        chk({tag, ".zcnv"},  {28'h0, o_z, o_c, o_n, o_v}, {28'h0, zcnv});
        chk({tag, ".err"},   {31'h0, o_err}, {31'h0, e});
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, {29'h0, o_done, o_err, o_busy}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; t_start = 1'b0; sel16 = 1'b0;
        t_op = 4'h0; t_a = '0; t_b = '0;
        #2;
        chk("rst8",  {o_res[15:0], o_hi[7:0], o_z, o_c, o_n, o_v, o_err, o_done, o_busy, 1'b0}, 32'h0);
        sel16 = 1'b1; #1;
        chk("rst16", {o_res[15:0], o_hi[15:9], o_z, o_c, o_n, o_v, o_err, o_done, o_busy, 1'b0}, 32'h0);
        sel16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(0, c_ADD, 32'hF0, 32'h20, 0, lat);
        expect_done("add8", lat, 1, 32'h10, 32'h0, 4'b0100, 1'b0);
        issue(0, c_SUB, 32'h05, 32'h05, 0, lat);
        expect_done("sub_zero", lat, 1, 32'h00, 32'h0, 4'b1000, 1'b0);
        issue(0, c_SUB, 32'h80, 32'h01, 0, lat);
        expect_done("sub_ovf", lat, 1, 32'h7F, 32'h0, 4'b0001, 1'b0);
        issue(0, c_SUB, 32'h01, 32'h02, 0, lat);
        expect_done("sub_borrow", lat, 1, 32'hFF, 32'h0, 4'b0110, 1'b0);
        issue(0, c_SHL, 32'h81, 32'h03, 0, lat);
        expect_done("shl3", lat, 4, 32'h08, 32'h0, 4'b0000, 1'b0);
        issue(0, c_SHR, 32'h81, 32'h01, 0, lat);
        expect_done("shr1", lat, 2, 32'h40, 32'h0, 4'b0100, 1'b0);
        issue(0, c_SHL, 32'h81, 32'h00, 0, lat);
        expect_done("shl0", lat, 1, 32'h81, 32'h0, 4'b0010, 1'b0);
        issue(0, c_MUL, 32'h00, 32'h37, 0, lat);
        expect_done("mul_zero", lat, 9, 32'h00, 32'h0, 4'b1000, 1'b0);
        issue(0, c_MUL, 32'hFF, 32'hFF, 1, lat);
        expect_done("mul_ff", lat, 9, 32'h01, 32'hFE, 4'b0100, 1'b0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_done) seen++;
        end
        chk("ignored_start.no_done", seen, 0);
        chk("ignored_start.res", {o_hi[7:0], o_res[7:0]}, 32'hFE01);

        // Abort a multiply with reset four cycles in
        @(negedge clk);
        sel16 = 1'b0; t_op = c_MUL; t_a = 32'h3; t_b = 32'h5; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.outs", {o_res, o_hi} == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        chk("midrst.flags", {25'h0, o_z, o_c, o_n, o_v, o_err, o_done, o_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_done || o_busy) seen++;
        end
        chk("midrst.no_done", seen, 0);

        issue(0, c_NOR, 32'h0F, 32'hF0, 0, lat);
        expect_done("nor", lat, 1, 32'h00, 32'h0, 4'b1000, 1'b0);
        issue(0, c_ADD, 32'h01, 32'h01, 0, lat);
        expect_done("add_11", lat, 1, 32'h02, 32'h0, 4'b0000, 1'b0);
        issue(0, 4'b0000, 32'h55, 32'hAA, 0, lat);
        expect_done("illegal0", lat, 1, 32'h02, 32'h0, 4'b0000, 1'b1);
        issue(0, c_SUB, 32'h01, 32'h02, 0, lat);
        expect_done("sub_pre", lat, 1, 32'hFF, 32'h0, 4'b0110, 1'b0);
        issue(0, 4'b1111, 32'h00, 32'h00, 0, lat);
        expect_done("illegalF", lat, 1, 32'hFF, 32'h0, 4'b0110, 1'b1);

        issue(1, c_ADD, 32'hF0, 32'h20, 0, lat);
        expect_done("add16", lat, 1, 32'h0110, 32'h0, 4'b0000, 1'b0);
        issue(1, c_ADD, 32'hFFFF, 32'h0001, 0, lat);
        expect_done("add16_wrap", lat, 1, 32'h0000, 32'h0, 4'b1100, 1'b0);
        issue(1, c_MUL, 32'hFFFF, 32'h0002, 0, lat);
        expect_done("mul16", lat, 17, 32'hFFFE, 32'h0001, 4'b0110, 1'b0);
        issue(1, c_MUL, 32'h00FF, 32'h00FF, 0, lat);
        expect_done("mul16_nohi", lat, 17, 32'hFE01, 32'h0000, 4'b0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
